// File: rtl/seg7_scanner.sv
// seg7_scanner: multiplexed seven-segment driver. It shares one segment bus
// across DIGITS digits and supports per-digit enables, decimal points,
// leading-zero suppression and a blanking window at the start of each slot
// to suppress ghosting. New values are staged and only shown from the next
// frame boundary, so a frame never mixes old and new digits.
module seg7_scanner #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_load,
  input  logic [DIGITS-1:0]     i_digit_en,
  input  logic                  i_lz_suppress,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_dig,
  output logic                  o_frame_tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  BLANK_L  = CNT_W'(BLANK_CYCLES);

  // Idle levels of the pins after polarity is applied.
  localparam logic [7:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF  = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_stageVal;
  logic [DIGITS-1:0]   r_stageDp;
  logic [4*DIGITS-1:0] r_shadowVal;
  logic [DIGITS-1:0]   r_shadowDp;
  logic                r_pending;

  logic                w_slotEnd;
  logic                w_eof;
  logic [3:0]          w_nibble;
  logic                w_dpBit;
  logic                w_en;
  logic                w_upperZero;
  logic                w_lzBlank;
  logic [6:0]          w_glyph;
  logic [7:0]          w_segRaw;
  logic                w_digActive;
  logic [DIGITS-1:0]   w_digRaw;

  assign w_slotEnd = (r_cnt == CNT_LAST);
  assign w_eof     = w_slotEnd && (r_idx == IDX_LAST);

  // Slot counter and digit index; every digit owns a full slot whether enabled or not.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slotEnd) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Double buffer: loads land in staging and reach the shadow only at end of frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stageVal  <= '0;
      r_stageDp   <= '0;
      r_shadowVal <= '0;
      r_shadowDp  <= '0;
      r_pending   <= 1'b0;
    end else if (i_load && w_eof) begin
      r_stageVal  <= i_value;
      r_stageDp   <= i_dp;
      r_shadowVal <= i_value;
      r_shadowDp  <= i_dp;
      r_pending   <= 1'b0;
    end else if (i_load) begin
      r_stageVal  <= i_value;
      r_stageDp   <= i_dp;
      r_pending   <= 1'b1;
    end else if (w_eof && r_pending) begin
      r_shadowVal <= r_stageVal;
      r_shadowDp  <= r_stageDp;
      r_pending   <= 1'b0;
    end
  end

  // Pick the current digit's nibble, dp and enable, and see whether it and all higher digits are zero.
  always_comb begin
    w_nibble    = 4'h0;
    w_dpBit     = 1'b0;
    w_en        = 1'b0;
    w_upperZero = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble = r_shadowVal[4*i +: 4];
        w_dpBit  = r_shadowDp[i];
        w_en     = i_digit_en[i];
      end
      if ((IDX_W'(i) >= r_idx) && (r_shadowVal[4*i +: 4] != 4'h0)) begin
        w_upperZero = 1'b0;
      end
    end
  end

  assign w_lzBlank = i_lz_suppress && (r_idx != '0) && w_upperZero;

  // Hex to segment glyph, active-high, bits g..a.
  always_comb begin
    w_glyph = 7'h00;
    case (w_nibble)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h58;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
      default: w_glyph = 7'h00;
    endcase
  end

  // A suppressed zero keeps its dp; the digit is only lit if that dp is set.
  assign w_segRaw    = {w_dpBit, (w_lzBlank ? 7'h00 : w_glyph)};
  assign w_digActive = (r_cnt >= BLANK_L) && w_en && !(w_lzBlank && !w_dpBit);

  // One-hot digit select for the current slot.
  always_comb begin
    w_digRaw = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      w_digRaw[i] = w_digActive && (r_idx == IDX_W'(i));
    end
  end

  // Output registers with polarity applied just before the flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg        <= SEG_OFF;
      o_dig        <= DIG_OFF;
      o_frame_tick <= 1'b0;
    end else begin
      o_seg        <= SEG_ACTIVE_LOW ? ~w_segRaw : w_segRaw;
      o_dig        <= DIG_ACTIVE_LOW ? ~w_digRaw : w_digRaw;
      o_frame_tick <= w_eof;
    end
  end

endmodule

// File: tb/tb_seg7_scanner.sv
// Testbench for seg7_scanner with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2,
// active-low segments and digits. A frame is 32 cycles; samples are taken
// on the falling edge and indexed by the scan position they display.
module tb_seg7_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic [3:0]  digit_en;
  logic        lz;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        ft;

  int checks = 0;
  int errors = 0;

  logic [7:0] sSeg [32];
  logic [3:0] sDig [32];
  logic       sFt  [32];
  logic [7:0] segExp [4];

  seg7_scanner #(
    .DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_dp(dp), .i_load(load),
    .i_digit_en(digit_en), .i_lz_suppress(lz),
    .o_seg(seg), .o_dig(dig), .o_frame_tick(ft)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected dig for scan position k (slot k/8, cnt k%8) when the slots in mask light up.
  function automatic logic [3:0] expDig(input int k, input logic [3:0] mask);
    int slot;
    int c;
    logic [3:0] t;
    slot = k / 8;
    c = k % 8;
    t = 4'b0001 << slot;
    if (c >= 2 && mask[slot]) return ~t;
    return 4'hF;
  endfunction

  // Runs one frame starting at a frame_tick sample, with up to two load pulses at given steps.
  task automatic runFrame(input int at1, input logic [15:0] v1, input logic [3:0] d1,
                          input int at2, input logic [15:0] v2, input logic [3:0] d2);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      sSeg[j] = seg;
      sDig[j] = dig;
      sFt[j]  = ft;
      if (j == at1) begin
        value = v1; dp = d1; load = 1'b1;
      end else if (j == at2) begin
        value = v2; dp = d2; load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; value = 16'h0; dp = 4'h0; load = 1'b0; digit_en = 4'hF; lz = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (seg !== 8'hFF || dig !== 4'hF || ft !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold actual seg=%h dig=%h ft=%b required seg=FF dig=F ft=0", seg, dig, ft);
      end
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      checks++;
      if (seg !== 8'hC0) begin
        errors++;
        $display("[TB] FAIL reset_seg n=%0d actual=%h required=C0", n, seg);
      end
      checks++;
      if (dig !== expDig(n - 1, 4'hF)) begin
        errors++;
        $display("[TB] FAIL reset_dig n=%0d actual=%b required=%b", n, dig, expDig(n - 1, 4'hF));
      end
      checks++;
      if (ft !== (n == 32)) begin
        errors++;
        $display("[TB] FAIL reset_first_tick n=%0d actual=%b required=%b", n, ft, (n == 32));
      end
    end
  endtask

  task automatic test_load();
    runFrame(5, 16'h12A0, 4'b0010, -1, 16'h0, 4'h0);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (sSeg[k] !== 8'hC0) begin
        errors++;
        $display("[TB] FAIL load_no_tear k=%0d actual=%h required=C0", k, sSeg[k]);
      end
      checks++;
      if (sFt[k] !== (k == 31)) begin
        errors++;
        $display("[TB] FAIL load_tick1 k=%0d actual=%b required=%b", k, sFt[k], (k == 31));
      end
    end
    segExp[0] = 8'hC0; segExp[1] = 8'h08; segExp[2] = 8'hA4; segExp[3] = 8'hF9;
    repeat (2) begin
      runFrame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (sSeg[k] !== segExp[k / 8]) begin
          errors++;
          $display("[TB] FAIL load_seg k=%0d actual=%h required=%h", k, sSeg[k], segExp[k / 8]);
        end
        checks++;
        if (sDig[k] !== expDig(k, 4'hF)) begin
          errors++;
          $display("[TB] FAIL load_dig k=%0d actual=%b required=%b", k, sDig[k], expDig(k, 4'hF));
        end
        checks++;
        if (sFt[k] !== (k == 31)) begin
          errors++;
          $display("[TB] FAIL load_period k=%0d actual=%b required=%b", k, sFt[k], (k == 31));
        end
      end
    end
  endtask

  task automatic test_lz_suppress();
    lz = 1'b1;
    runFrame(5, 16'h0050, 4'h0, -1, 16'h0, 4'h0);
    runFrame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    segExp[0] = 8'hC0; segExp[1] = 8'h92; segExp[2] = 8'hFF; segExp[3] = 8'hFF;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (sSeg[k] !== segExp[k / 8]) begin
        errors++;
        $display("[TB] FAIL lz_seg k=%0d actual=%h required=%h", k, sSeg[k], segExp[k / 8]);
      end
      checks++;
      if (sDig[k] !== expDig(k, 4'b0011)) begin
        errors++;
        $display("[TB] FAIL lz_dig k=%0d actual=%b required=%b", k, sDig[k], expDig(k, 4'b0011));
      end
    end
    lz = 1'b0;
    runFrame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    segExp[2] = 8'hC0; segExp[3] = 8'hC0;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (sSeg[k] !== segExp[k / 8]) begin
        errors++;
        $display("[TB] FAIL nolz_seg k=%0d actual=%h required=%h", k, sSeg[k], segExp[k / 8]);
      end
      checks++;
      if (sDig[k] !== expDig(k, 4'hF)) begin
        errors++;
        $display("[TB] FAIL nolz_dig k=%0d actual=%b required=%b", k, sDig[k], expDig(k, 4'hF));
      end
    end
  endtask

  task automatic test_back_to_back();
    // Step 30 drives load so it is sampled on the end-of-frame edge.
    runFrame(5, 16'h1111, 4'h0, 30, 16'hFFFF, 4'h0);
    repeat (2) begin
      runFrame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (sSeg[k] !== 8'h8E) begin
          errors++;
          $display("[TB] FAIL eof_load_seg k=%0d actual=%h required=8E", k, sSeg[k]);
        end
        checks++;
        if (sDig[k] !== expDig(k, 4'hF)) begin
          errors++;
          $display("[TB] FAIL eof_load_dig k=%0d actual=%b required=%b", k, sDig[k], expDig(k, 4'hF));
        end
      end
    end
  endtask

  task automatic test_digit_en();
    digit_en = 4'b0101;
    runFrame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (sDig[k] !== expDig(k, 4'b0101)) begin
        errors++;
        $display("[TB] FAIL en_dig k=%0d actual=%b required=%b", k, sDig[k], expDig(k, 4'b0101));
      end
      checks++;
      if (sFt[k] !== (k == 31)) begin
        errors++;
        $display("[TB] FAIL en_period k=%0d actual=%b required=%b", k, sFt[k], (k == 31));
      end
    end
    digit_en = 4'hF;
  endtask

  task automatic test_reset_mid();
    runFrame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    repeat (21) @(negedge clk);
    checks++;
    if (dig !== 4'b1011 || seg !== 8'h8E) begin
      errors++;
      $display("[TB] FAIL mid_before actual seg=%h dig=%b required seg=8E dig=1011", seg, dig);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 8'hFF || dig !== 4'hF || ft !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_async actual seg=%h dig=%b ft=%b required seg=FF dig=1111 ft=0", seg, dig, ft);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      checks++;
      if (seg !== 8'hC0) begin
        errors++;
        $display("[TB] FAIL mid_after_seg n=%0d actual=%h required=C0", n, seg);
      end
      checks++;
      if (dig !== expDig(n - 1, 4'hF)) begin
        errors++;
        $display("[TB] FAIL mid_after_dig n=%0d actual=%b required=%b", n, dig, expDig(n - 1, 4'hF));
      end
      checks++;
      if (ft !== (n == 32)) begin
        errors++;
        $display("[TB] FAIL mid_after_tick n=%0d actual=%b required=%b", n, ft, (n == 32));
      end
    end
  endtask

  // Scenarios run back to back; each one starts and ends on a frame_tick sample.
  initial begin
    test_reset();
    test_load();
    test_lz_suppress();
    test_back_to_back();
    test_digit_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
